arpas_steer_ctl: RTL and testbench

//  Sequencer for the arpasmxm3 left/right signal router. Accepts one transfer

---
 rtl/arpas_steer_ctl.sv | 189 ++++++++++++++++++
 tb/tb_arpas_steer_ctl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arpas_steer_ctl.sv
// ---------------------------------------------------------------------------
// arpas_steer_ctl
// Sequencer for one arpasmxm3 left/right signal router. It accepts a single
// transfer request (destination + length) and steers the router toward the
// destination when its feedback disagrees. Steering is normally done with an
// inc toggle pulse followed by a settle wait, or with a rev flip in the fast
// build. Once the router points the right way, din is gated onto sig for len
// cycles and done is pulsed.
//
// Optional feature macro: REV_FAST_EN
//   defined   : steering flips rev, the settle wait is skipped, inc stays 0
//   undefined : rev stays at REV_INIT, steering uses an inc pulse plus settle
//
// Parameters
//   LW        width of len and of the transfer/settle counter
//   SETTLE    idle cycles after an inc pulse before feedback is trusted (>=1)
//   REV_INIT  reset value of rev
//
// Ports
//   c     in   clock, rising edge
//   rn    in   asynchronous active-low reset
//   req   in   transfer request, sampled only while idle
//   dst   in   destination (0 = left, 1 = right), sampled with req
//   len   in   number of sig cycles, sampled with req
//   fb    in   router effective select feedback (0 = left, 1 = right)
//   din   in   data bit to route
//   inc   out  router toggle pulse (registered)
//   rev   out  router reverse control (registered)
//   sig   out  din while transferring, else 0
//   busy  out  high whenever the sequencer is not idle (registered)
//   done  out  one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
module arpas_steer_ctl #(
  parameter int   LW       = 4,
  parameter int   SETTLE   = 2,
  parameter logic REV_INIT = 1'b0
) (
  input  logic          c,
  input  logic          rn,
  input  logic          req,
  input  logic          dst,
  input  logic [LW-1:0] len,
  input  logic          fb,
  input  logic          din,
  output logic          inc,
  output logic          rev,
  output logic          sig,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STEER  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_XFER   = 2'd3;

  localparam logic [LW-1:0] CNT_ZERO    = LW'(0);
  localparam logic [LW-1:0] CNT_ONE     = LW'(1);
  localparam logic [LW-1:0] SETTLE_INIT = LW'(SETTLE - 1);

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] cnt_q,   cnt_d;
  logic [LW-1:0] len_q,   len_d;
  logic          dst_q,   dst_d;
  logic          inc_q,   inc_d;
  logic          rev_q,   rev_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          zero_done_s;

  // Next-state, counter and request-latch logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    dst_d       = dst_q;
    zero_done_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q high while idle means a zero-length request just finished;
        // a request in that cycle is deliberately left for the next one.
        if (req && !done_q) begin
          dst_d = dst;
          len_d = len;
          if (fb == dst) begin
            if (len == CNT_ZERO) begin
              zero_done_s = 1'b1;
            end else begin
              state_d = S_XFER;
              cnt_d   = len - CNT_ONE;
            end
          end else begin
            state_d = S_STEER;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STEER: begin
`ifdef REV_FAST_EN
        // rev acts combinationally in the router, so no settle is needed.
        if (len_q == CNT_ZERO) begin
          state_d     = S_IDLE;
          zero_done_s = 1'b1;
        end else begin
          state_d = S_XFER;
          cnt_d   = len_q - CNT_ONE;
        end
`else
        state_d = S_SETTLE;
        cnt_d   = SETTLE_INIT;
`endif
      end
      S_SETTLE: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (fb == dst_q) begin
          if (len_q == CNT_ZERO) begin
            state_d     = S_IDLE;
            zero_done_s = 1'b1;
          end else begin
            state_d = S_XFER;
            cnt_d   = len_q - CNT_ONE;
          end
        end else begin
          // Router did not follow the toggle: pulse it again.
          state_d = S_STEER;
        end
      end
      S_XFER: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Registered output decode, computed from the next state so the outputs
  // line up with the state they describe.
  always_comb begin
`ifdef REV_FAST_EN
    inc_d = 1'b0;
    rev_d = rev_q ^ (state_d == S_STEER);
`else
    inc_d = (state_d == S_STEER);
    rev_d = rev_q;
`endif
    busy_d = (state_d != S_IDLE);
    // done marks the final XFER cycle, or the idle cycle after a zero-length
    // request completes.
    done_d = zero_done_s || ((state_d == S_XFER) && (cnt_d == CNT_ZERO));
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      len_q   <= CNT_ZERO;
      dst_q   <= 1'b0;
      inc_q   <= 1'b0;
      rev_q   <= REV_INIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dst_q   <= dst_d;
      inc_q   <= inc_d;
      rev_q   <= rev_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inc  = inc_q;
  assign rev  = rev_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sig  = din & (state_q == S_XFER);

endmodule

// File: tb/tb_arpas_steer_ctl.sv
module tb_arpas_steer_ctl;

  logic       c;
  logic       rn;
  logic       req;
  logic       dst;
  logic [3:0] len;
  logic       fb;
  logic       din;
  logic       inc;
  logic       rev;
  logic       sig;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  // Router model: inc toggles the internal select, rev inverts it.
  logic tog;
  logic tog_clr;
  logic model_en;
  logic fb_stuck;

  assign fb = model_en ? (tog ^ rev) : fb_stuck;

  always @(posedge c) begin
    if (tog_clr) tog <= 1'b0;
    else if (inc) tog <= ~tog;
  end

  arpas_steer_ctl #(.LW(4), .SETTLE(2), .REV_INIT(1'b0)) dut (
    .c(c), .rn(rn), .req(req), .dst(dst), .len(len), .fb(fb), .din(din),
    .inc(inc), .rev(rev), .sig(sig), .busy(busy), .done(done)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic next_cycle();
    @(posedge c);
    #1;
  endtask

  task automatic do_reset();
    @(negedge c);
    rn = 1'b0; req = 1'b0; din = 1'b0; tog_clr = 1'b1;
    @(posedge c);
    @(negedge c);
    rn = 1'b1;
    @(posedge c);
    #1;
    tog_clr = 1'b0;
  endtask

  task automatic test_reset();
    rn = 1'b0; req = 1'b0; dst = 1'b0; len = 4'd0; din = 1'b1;
    tog_clr = 1'b1; model_en = 1'b1; fb_stuck = 1'b0;
    #1;
    checks++; if ({inc, rev, sig, busy, done} !== 5'b00000) begin
      failures++; $display("FAIL reset_async: got %b want 00000", {inc, rev, sig, busy, done});
    end
    req = 1'b1;
    repeat (3) next_cycle();
    checks++; if ({inc, rev, sig, busy, done} !== 5'b00000) begin
      failures++; $display("FAIL reset_held: got %b want 00000", {inc, rev, sig, busy, done});
    end
    req = 1'b0;
    @(negedge c);
    rn = 1'b1;
    next_cycle();
    tog_clr = 1'b0;
  endtask

  // fb=0, dst=0, len=3: no steering, sig N+1..N+3, done at N+3.
  task automatic test_no_steer();
    logic [3:0] din_pat;
    din_pat = 4'b1101;
    next_cycle();
    req = 1'b1; dst = 1'b0; len = 4'd3; din = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin
      failures++; $display("FAIL ns_busy_N: got %b want 0", busy);
    end
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      req = 1'b0; din = din_pat[k-1];
      #1;
      checks++; if (sig !== (din_pat[k-1] && k <= 3)) begin
        failures++; $display("FAIL ns_sig k=%0d: got %b want %b", k, sig, din_pat[k-1] && k <= 3);
      end
      checks++; if (done !== (k == 3)) begin
        failures++; $display("FAIL ns_done k=%0d: got %b want %b", k, done, k == 3);
      end
      checks++; if (busy !== (k <= 3)) begin
        failures++; $display("FAIL ns_busy k=%0d: got %b want %b", k, busy, k <= 3);
      end
      checks++; if (inc !== 1'b0) begin
        failures++; $display("FAIL ns_inc k=%0d: got %b want 0", k, inc);
      end
    end
  endtask

  // fb=0, dst=1, len=2: inc at N+1, sig N+4..N+5, done N+5.
  task automatic test_steer();
    next_cycle();
    model_en = 1'b1;
    req = 1'b1; dst = 1'b1; len = 4'd2; din = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      req = 1'b0;
      #1;
      checks++; if (inc !== (k == 1)) begin
        failures++; $display("FAIL st_inc k=%0d: got %b want %b", k, inc, k == 1);
      end
      checks++; if (sig !== (k == 4 || k == 5)) begin
        failures++; $display("FAIL st_sig k=%0d: got %b want %b", k, sig, k == 4 || k == 5);
      end
      checks++; if (done !== (k == 5)) begin
        failures++; $display("FAIL st_done k=%0d: got %b want %b", k, done, k == 5);
      end
      checks++; if (busy !== (k <= 5)) begin
        failures++; $display("FAIL st_busy k=%0d: got %b want %b", k, busy, k <= 5);
      end
      checks++; if (rev !== 1'b0) begin
        failures++; $display("FAIL st_rev k=%0d: got %b want 0", k, rev);
      end
    end
    checks++; if (fb !== 1'b1) begin
      failures++; $display("FAIL st_routed_right: got %b want 1", fb);
    end
  endtask

  // fb stuck at 0 with dst=1: inc retried every 3 cycles, never transfers.
  task automatic test_stuck_retry();
    next_cycle();
    model_en = 1'b0; fb_stuck = 1'b0;
    req = 1'b1; dst = 1'b1; len = 4'd2; din = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      next_cycle();
      req = 1'b0;
      #1;
      checks++; if (inc !== ((k % 3) == 1)) begin
        failures++; $display("FAIL sr_inc k=%0d: got %b want %b", k, inc, (k % 3) == 1);
      end
      checks++; if ({sig, busy, done} !== 3'b010) begin
        failures++; $display("FAIL sr_sbd k=%0d: got %b want 010", k, {sig, busy, done});
      end
    end
    model_en = 1'b1;
    do_reset();
  endtask

  // len=0 with fb==dst, req held through the done cycle, req while busy.
  task automatic test_zero_len();
    next_cycle();
    req = 1'b1; dst = 1'b0; len = 4'd0; din = 1'b1;
    next_cycle();
    dst = 1'b1; len = 4'd2;
    #1;
    checks++; if ({inc, sig, busy, done} !== 4'b0001) begin
      failures++; $display("FAIL zl_done_cycle: got %b want 0001", {inc, sig, busy, done});
    end
    next_cycle();
    dst = 1'b0; len = 4'd2;
    #1;
    checks++; if ({inc, busy, done} !== 3'b000) begin
      failures++; $display("FAIL zl_not_sampled: got %b want 000", {inc, busy, done});
    end
    next_cycle();
    dst = 1'b1; len = 4'd5;
    #1;
    checks++; if ({sig, busy, done} !== 3'b110) begin
      failures++; $display("FAIL zl_accept_next: got %b want 110", {sig, busy, done});
    end
    next_cycle();
    req = 1'b0;
    #1;
    checks++; if ({sig, busy, done} !== 3'b111) begin
      failures++; $display("FAIL zl_xfer_done: got %b want 111", {sig, busy, done});
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      checks++; if ({inc, sig, busy, done} !== 4'b0000) begin
        failures++; $display("FAIL zl_busy_req_ignored k=%0d: got %b want 0000", k, {inc, sig, busy, done});
      end
    end
  endtask

  // Reset during XFER clears outputs at once and suppresses done.
  task automatic test_reset_mid_xfer();
    next_cycle();
    req = 1'b1; dst = 1'b0; len = 4'd5; din = 1'b1;
    next_cycle();
    req = 1'b0;
    next_cycle();
    #1;
    checks++; if ({sig, busy} !== 2'b11) begin
      failures++; $display("FAIL rx_pre: got %b want 11", {sig, busy});
    end
    #1;
    rn = 1'b0;
    #1;
    checks++; if ({inc, rev, sig, busy, done} !== 5'b00000) begin
      failures++; $display("FAIL rx_async: got %b want 00000", {inc, rev, sig, busy, done});
    end
    @(negedge c);
    rn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      #1;
      checks++; if ({inc, sig, busy, done} !== 4'b0000) begin
        failures++; $display("FAIL rx_after k=%0d: got %b want 0000", k, {inc, sig, busy, done});
      end
    end
  endtask

`ifdef REV_FAST_EN
  // Fast steering: rev flips at N+1, sig N+2..N+3, done N+3, inc never.
  task automatic test_rev_fast();
    next_cycle();
    model_en = 1'b1;
    req = 1'b1; dst = 1'b1; len = 4'd2; din = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      req = 1'b0;
      #1;
      checks++; if (rev !== 1'b1) begin
        failures++; $display("FAIL rf_rev k=%0d: got %b want 1", k, rev);
      end
      checks++; if (inc !== 1'b0) begin
        failures++; $display("FAIL rf_inc k=%0d: got %b want 0", k, inc);
      end
      checks++; if (sig !== (k == 2 || k == 3)) begin
        failures++; $display("FAIL rf_sig k=%0d: got %b want %b", k, sig, k == 2 || k == 3);
      end
      checks++; if (done !== (k == 3)) begin
        failures++; $display("FAIL rf_done k=%0d: got %b want %b", k, done, k == 3);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_no_steer();
`ifdef REV_FAST_EN
    test_zero_len();
    test_reset_mid_xfer();
    test_rev_fast();
`else
    test_steer();
    test_stuck_retry();
    test_zero_len();
    test_reset_mid_xfer();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
